// File: rtl/dlx_data_memory_ctrl.sv
// rtl/dlx_data_memory_ctrl.sv - DLX data-side memory: word RAM plus GPIO/timer MMIO page
module dlx_data_memory_ctrl #(
   parameter int                          DATA_WIDTH      = 32,
   parameter int                          DATA_ADDR_WIDTH = 32,
   parameter int                          RAM_ADDR_WIDTH  = 10,
   parameter logic [DATA_ADDR_WIDTH-1:0]  IO_BASE         = 32'hFFFF_FF00
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       data_rd_en,
   input  logic                       data_wr_en,
   input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0]      data_write,
   output logic [DATA_WIDTH-1:0]      data_read,
   output logic [DATA_WIDTH-1:0]      gpio_out,
   output logic                       timer_irq,
   output logic                       bus_error
);

   localparam int                  RAM_WORDS = 1 << RAM_ADDR_WIDTH;
   localparam logic [7:0]          OFF_GPIO   = 8'h00;
   localparam logic [7:0]          OFF_COUNT  = 8'h04;
   localparam logic [7:0]          OFF_CMP    = 8'h08;
   localparam logic [7:0]          OFF_CTRL   = 8'h0C;
   localparam logic [7:0]          OFF_STATUS = 8'h10;
   localparam logic [DATA_WIDTH-1:0] ONE    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0]     mem [RAM_WORDS];
   logic [DATA_WIDTH-1:0]     count, cmp, count_nxt, rd_word;
   logic [2:0]                ctrl;          // {irq_en, auto_reload, enable}
   logic                      st_match, st_err, match_hit;
   logic                      misaligned, is_ram, is_io, illegal, wr_ok, rd_ok;
   logic                      wr_gpio, wr_count, wr_cmp, wr_ctrl, wr_status;
   logic [RAM_ADDR_WIDTH-1:0] ram_idx;
   logic [7:0]                io_off;

   assign misaligned = |data_addr[1:0];
   assign is_ram     = (data_addr[DATA_ADDR_WIDTH-1:RAM_ADDR_WIDTH+2] == '0);
   assign is_io      = (data_addr[DATA_ADDR_WIDTH-1:8] == IO_BASE[DATA_ADDR_WIDTH-1:8]);
   assign ram_idx    = data_addr[RAM_ADDR_WIDTH+1:2];
   assign io_off     = data_addr[7:0];

   // A simultaneous read+write is treated like a bad address: nothing moves but err.
   assign illegal = (data_rd_en | data_wr_en) &
                    (misaligned | ~(is_ram | is_io) | (data_rd_en & data_wr_en));
   assign wr_ok   = data_wr_en & ~illegal;
   assign rd_ok   = data_rd_en & ~illegal;

   assign wr_gpio   = wr_ok & is_io & (io_off == OFF_GPIO);
   assign wr_count  = wr_ok & is_io & (io_off == OFF_COUNT);
   assign wr_cmp    = wr_ok & is_io & (io_off == OFF_CMP);
   assign wr_ctrl   = wr_ok & is_io & (io_off == OFF_CTRL);
   assign wr_status = wr_ok & is_io & (io_off == OFF_STATUS);

   always_comb begin
      rd_word = '0;
      if (is_ram) begin
         rd_word = mem[ram_idx];
      end else if (is_io) begin
         case (io_off)
            OFF_GPIO:   rd_word = gpio_out;
            OFF_COUNT:  rd_word = count;
            OFF_CMP:    rd_word = cmp;
            OFF_CTRL:   rd_word = {{(DATA_WIDTH-3){1'b0}}, ctrl};
            OFF_STATUS: rd_word = {{(DATA_WIDTH-2){1'b0}}, st_err, st_match};
            default:    rd_word = '0;
         endcase
      end
   end

   // Match is judged on the pre-edge COUNT; a software write still wins the next value.
   always_comb begin
      match_hit = ctrl[0] && (count == cmp);
      count_nxt = count;
      if (ctrl[0]) begin
         count_nxt = (match_hit && ctrl[1]) ? '0 : count + ONE;
      end
      if (wr_count) begin
         count_nxt = data_write;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok && is_ram) begin
         mem[ram_idx] <= data_write;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_read <= '0;
         gpio_out  <= '0;
         count     <= '0;
         cmp       <= '1;
         ctrl      <= '0;
         st_match  <= 1'b0;
         st_err    <= 1'b0;
      end else begin
         if (data_rd_en) begin
            data_read <= rd_ok ? rd_word : '0;
         end
         if (wr_gpio) gpio_out <= data_write;
         if (wr_cmp)  cmp      <= data_write;
         if (wr_ctrl) ctrl     <= data_write[2:0];
         count    <= count_nxt;
         st_match <= match_hit | (st_match & ~(wr_status & data_write[0]));
         st_err   <= illegal   | (st_err   & ~(wr_status & data_write[1]));
      end
   end

   assign timer_irq = st_match & ctrl[2];
   assign bus_error = st_err;

endmodule

// File: tb/tb_dlx_data_memory_ctrl.sv
// tb/tb_dlx_data_memory_ctrl.sv - directed scoreboard bench for dlx_data_memory_ctrl
module tb_dlx_data_memory_ctrl;

   localparam logic [31:0] IO     = 32'hFFFF_FF00;
   localparam logic [31:0] GPIO   = IO + 32'h00;
   localparam logic [31:0] COUNT  = IO + 32'h04;
   localparam logic [31:0] CMP    = IO + 32'h08;
   localparam logic [31:0] CTRL   = IO + 32'h0C;
   localparam logic [31:0] STATUS = IO + 32'h10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en = 1'b0, wr_en = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] data_read, gpio_out;
   logic        timer_irq, bus_error;
   logic [31:0] exp_q [$];
   int          total = 0, bad = 0;

   dlx_data_memory_ctrl dut (
      .clk(clk), .rst_n(rst_n), .data_rd_en(rd_en), .data_wr_en(wr_en),
      .data_addr(addr), .data_write(wdata), .data_read(data_read),
      .gpio_out(gpio_out), .timer_irq(timer_irq), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [31:0] e;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      wr_en = 1'b0;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("data_read", data_read, e);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wr_en = 1'b1; addr = a; wdata = d;
      tick();
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e);
      rd_en = 1'b1; addr = a;
      exp_q.push_back(e);
      tick();
   endtask

   initial begin
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst data_read", data_read, 32'h0);
      check("rst gpio_out", gpio_out, 32'h0);
      check("rst timer_irq", {31'b0, timer_irq}, 32'h0);
      check("rst bus_error", {31'b0, bus_error}, 32'h0);
      rd(COUNT, 32'h0);
      rd(CMP, 32'hFFFF_FFFF);
      rd(CTRL, 32'h0);
      rd(STATUS, 32'h0);

      // RAM write then read, data held while idle
      wr(32'h10, 32'hDEAD_BEEF);
      rd(32'h10, 32'hDEAD_BEEF);
      tick();
      check("hold data_read", data_read, 32'hDEAD_BEEF);
      wr(32'hFFC, 32'h1234_5678);
      rd(32'hFFC, 32'h1234_5678);

      // free-running timer with irq
      wr(CMP, 32'd5);
      wr(CTRL, 32'b101);
      for (int i = 0; i < 8; i++) begin
         rd(COUNT, i);
         check("irq ramp", {31'b0, timer_irq}, (i >= 5) ? 32'h1 : 32'h0);
      end
      wr(STATUS, 32'h1);
      check("irq cleared", {31'b0, timer_irq}, 32'h0);

      // auto-reload sequence, sticky match without irq
      wr(CTRL, 32'h0);
      wr(COUNT, 32'h0);
      wr(STATUS, 32'h3);
      wr(CMP, 32'd3);
      wr(CTRL, 32'b011);
      for (int i = 0; i < 9; i++) rd(COUNT, i % 4);
      rd(STATUS, 32'h1);
      check("irq masked", {31'b0, timer_irq}, 32'h0);
      wr(COUNT, 32'd100);
      rd(COUNT, 32'd100);
      wr(CTRL, 32'h0);

      // misaligned / unmapped reads
      rd(32'h10, 32'hDEAD_BEEF);
      rd(32'h2, 32'h0);
      check("misaligned err", {31'b0, bus_error}, 32'h1);
      wr(STATUS, 32'h2);
      check("err cleared", {31'b0, bus_error}, 32'h0);
      rd(32'h10, 32'hDEAD_BEEF);
      rd(32'h8000_0000, 32'h0);
      check("unmapped err", {31'b0, bus_error}, 32'h1);
      wr(STATUS, 32'h2);

      // rd+wr collision, GPIO, CTRL masking, unused offset
      wr(32'h20, 32'h1111_1111);
      rd_en = 1'b1; wr_en = 1'b1; addr = 32'h20; wdata = 32'h2222_2222;
      exp_q.push_back(32'h0);
      tick();
      check("collision err", {31'b0, bus_error}, 32'h1);
      rd(32'h20, 32'h1111_1111);
      wr(STATUS, 32'h2);
      wr(GPIO, 32'hA5);
      check("gpio_out", gpio_out, 32'hA5);
      rd(GPIO, 32'hA5);
      wr(CTRL, 32'hFFFF_FFF8);
      rd(CTRL, 32'h0);
      rd(IO + 32'h14, 32'h0);
      check("no err unused off", {31'b0, bus_error}, 32'h0);

      // asynchronous reset during a running timer with a read in flight
      wr(CTRL, 32'b001);
      wr(GPIO, 32'h5A);
      rd(32'h10, 32'hDEAD_BEEF);
      rd_en = 1'b1; addr = COUNT;
      #2 rst_n = 1'b0;
      #1;
      check("async data_read", data_read, 32'h0);
      check("async gpio_out", gpio_out, 32'h0);
      rd_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rd(COUNT, 32'h0);
      rd(CTRL, 32'h0);
      rd(CMP, 32'hFFFF_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
